// File: rtl/clk_switch_ctrl.sv
// ============================================================================
// Module   : clk_switch_ctrl
// Purpose  : Sequencer for the sel[1:0] input of a two-level glitch-free clock
//            mux (sel[0] picks A/B, sel[1] picks that result or C).
//            It accepts source-change requests over a valid/ready handshake
//            and changes one sel bit at a time. After every bit change it
//            holds for SETTLE_CYC cycles. The inner bit is changed only while
//            it is hidden behind C, or when switching directly between A and B.
// Ports    : clk_i        always-on reference clock
//            rstn_i       asynchronous reset, active low
//            req_valid_i  switch request valid
//            req_src_i    requested source (0=A, 1=B, 2=C, 3=illegal)
//            req_ready_o  high while idle; request taken on valid && ready
//            src_ok_i     per-source clock-available flags [C,B,A]
//            sel_o        mux select (A=00, B=01, C=1x)
//            cur_src_o    source currently committed
//            busy_o       switch in progress
//            done_o       1-cycle pulse: switch or no-op complete
//            err_o        1-cycle pulse: request rejected
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module clk_switch_ctrl #(
  parameter int SETTLE_CYC = 4,
  parameter int RST_SRC    = 0
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic       req_valid_i,
  input  logic [1:0] req_src_i,
  output logic       req_ready_o,
  input  logic [2:0] src_ok_i,
  output logic [1:0] sel_o,
  output logic [1:0] cur_src_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       err_o
);

  localparam int         CNT_W    = $clog2(SETTLE_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYC - 1);
  localparam logic [1:0] RST_CUR  = 2'(RST_SRC);
  // C is encoded with the hidden inner bit cleared.
  localparam logic [1:0] RST_SEL  = (RST_SRC == 2) ? 2'b10 : 2'(RST_SRC);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_INNER = 2'd1;
  localparam logic [1:0] ST_OUTER = 2'd2;

  logic [1:0]       state;
  logic [1:0]       target;
  logic             outer_pend;
  logic [CNT_W-1:0] cnt;

  logic src_avail;
  logic tgt_is_c;
  logic need_inner;
  logic need_outer;

  // Request decode against the current select; only used in IDLE.
  always_comb begin
    src_avail = 1'b0;
    case (req_src_i)
      2'd0:    src_avail = src_ok_i[0];
      2'd1:    src_avail = src_ok_i[1];
      2'd2:    src_avail = src_ok_i[2];
      default: src_avail = 1'b0;
    endcase
    tgt_is_c   = (req_src_i == 2'd2);
    // The inner bit is irrelevant for C, so it is left alone in that case.
    need_inner = !tgt_is_c && (sel_o[0] != req_src_i[0]);
    need_outer = (sel_o[1] != tgt_is_c);
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state       <= ST_IDLE;
      target      <= RST_CUR;
      outer_pend  <= 1'b0;
      cnt         <= '0;
      sel_o       <= RST_SEL;
      cur_src_o   <= RST_CUR;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      err_o       <= 1'b0;
      req_ready_o <= 1'b1;
    end else begin
      done_o <= 1'b0;
      err_o  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_valid_i && req_ready_o) begin
            if (!src_avail) begin
              err_o <= 1'b1;
            end else if (req_src_i == cur_src_o) begin
              done_o <= 1'b1;
            end else begin
              target      <= req_src_i;
              outer_pend  <= need_outer;
              cnt         <= CNT_LOAD;
              busy_o      <= 1'b1;
              req_ready_o <= 1'b0;
              // Any real switch needs at least one of the two steps.
              if (need_inner) begin
                sel_o[0] <= ~sel_o[0];
                state    <= ST_INNER;
              end else begin
                sel_o[1] <= ~sel_o[1];
                state    <= ST_OUTER;
              end
            end
          end
        end

        ST_INNER: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (outer_pend) begin
            sel_o[1] <= ~sel_o[1];
            cnt      <= CNT_LOAD;
            state    <= ST_OUTER;
          end else begin
            state       <= ST_IDLE;
            cur_src_o   <= target;
            done_o      <= 1'b1;
            busy_o      <= 1'b0;
            req_ready_o <= 1'b1;
          end
        end

        ST_OUTER: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            state       <= ST_IDLE;
            cur_src_o   <= target;
            done_o      <= 1'b1;
            busy_o      <= 1'b0;
            req_ready_o <= 1'b1;
          end
        end

        default: begin
          state       <= ST_IDLE;
          busy_o      <= 1'b0;
          req_ready_o <= 1'b1;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
